// File: rtl/snn_pkg.sv
// snn_pkg: shared SNN rate-domain defaults, window FSM encoding and saturating scale
package snn_pkg;
  localparam int RATE_WIDTH_DEF = 8;
  typedef enum logic {S_IDLE, S_ACCUM} win_state_t;
  function automatic logic [31:0] sat_scale(input logic [31:0] count, input int win_log2, input int rate_width);
    logic [63:0] s;
    logic [63:0] m;
    m = (64'd1 << rate_width) - 64'd1;
    s = win_log2 >= rate_width ? {32'd0, count} >> (win_log2 - rate_width) : {32'd0, count} << (rate_width - win_log2);
    return s > m ? m[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/spike_window_counter.sv
// spike_window_counter: counts spikes over 2^WIN_LOG2 enabled samples and flags window completion
module spike_window_counter
  import snn_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              spike_in,
  output logic              window_done,
  output logic [WIN_LOG2:0] final_count
);
  win_state_t            state;
  logic [WIN_LOG2-1:0]   samp_cnt;
  logic [WIN_LOG2:0]     spk_cnt;
  logic [WIN_LOG2-1:0]   samp_nxt;
  logic [WIN_LOG2:0]     spk_nxt;
  always_comb begin
    samp_nxt    = (state == S_IDLE ? '0 : samp_cnt) + 1'b1;
    spk_nxt     = (state == S_IDLE ? '0 : spk_cnt) + {{WIN_LOG2{1'b0}}, spike_in};
    window_done = en && !clear && state == S_ACCUM && &samp_cnt;
    final_count = spk_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= S_IDLE;
      samp_cnt <= '0;
      spk_cnt  <= '0;
    end else if (en) begin
      state    <= S_ACCUM;
      samp_cnt <= samp_nxt;
      spk_cnt  <= window_done ? '0 : spk_nxt;
    end
  end
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed spike counter scaled to an encoder rate, presented on valid/ready
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int RATE_WIDTH = RATE_WIDTH_DEF,
  parameter int WIN_LOG2   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  spike_in,
  output logic [RATE_WIDTH-1:0] rate_out,
  output logic [WIN_LOG2:0]     count_out,
  output logic                  rate_valid,
  input  logic                  rate_ready,
  output logic                  overrun
);
  logic                  window_done;
  logic [WIN_LOG2:0]     final_count;
  logic [RATE_WIDTH-1:0] scaled;
  spike_window_counter #(.WIN_LOG2(WIN_LOG2)) u_win (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clear       (clear),
    .spike_in    (spike_in),
    .window_done (window_done),
    .final_count (final_count)
  );
  always_comb scaled = RATE_WIDTH'(sat_scale(32'(final_count), WIN_LOG2, RATE_WIDTH));
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_out   <= '0;
      count_out  <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= window_done && rate_valid && !rate_ready;
      if (window_done) begin
        rate_out   <= scaled;
        count_out  <= final_count;
        rate_valid <= 1'b1;
      end else if (rate_valid && rate_ready) begin
        rate_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: scoreboard bench for the windowed spike rate decoder
module tb_spike_rate_decoder;
  typedef struct {
    int r;
    int c;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic       spike_in = 1'b0;
  logic       rate_ready = 1'b1;
  logic [7:0] rate_out;
  logic [8:0] count_out;
  logic       rate_valid;
  logic       overrun;
  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         ov_cnt = 0;
  int         rate_sum = 0;
  spike_rate_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clear      (clear),
    .spike_in   (spike_in),
    .rate_out   (rate_out),
    .count_out  (count_out),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overrun    (overrun)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic e, input logic s);
    en = e;
    spike_in = s;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push(input int c);
    exp_t e;
    e.c = c;
    e.r = c > 255 ? 255 : c;
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (overrun) ov_cnt++;
        if (rate_valid && rate_ready) begin
          if (q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_rate", int'(rate_out), e.r);
            chk("sb_count", int'(count_out), e.c);
          end
        end
      end
    join_none
    idle(2);
    chk("rst_valid", int'(rate_valid), 0);
    chk("rst_rate", int'(rate_out), 0);
    chk("rst_count", int'(count_out), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    push(256);
    push(256);
    for (int i = 0; i < 512; i++) cyc(1'b1, 1'b1);
    idle(2);
    push(64);
    for (int i = 0; i < 256; i++) cyc(1'b1, i % 4 == 3);
    push(0);
    for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0);
    idle(2);
    push(256);
    for (int i = 0; i < 512; i++) cyc(i % 2 == 0, 1'b1);
    idle(2);
    rate_ready = 1'b0;
    push(96);
    for (int i = 0; i < 256; i++) cyc(1'b1, i % 8 == 0);
    chk("hold_valid", int'(rate_valid), 1);
    chk("hold_rate", int'(rate_out), 32);
    for (int i = 0; i < 256; i++) cyc(1'b1, i % 8 < 3);
    chk("ovr_pulse", int'(overrun), 1);
    chk("ovr_valid", int'(rate_valid), 1);
    chk("ovr_rate", int'(rate_out), 96);
    idle(1);
    chk("ovr_one_cycle", int'(overrun), 0);
    rate_ready = 1'b1;
    idle(1);
    rate_ready = 1'b0;
    chk("drop_after_xfer", int'(rate_valid), 0);
    rate_ready = 1'b1;
    for (int i = 0; i < 100; i++) cyc(1'b1, i < 30);
    clear = 1'b1;
    cyc(1'b1, 1'b1);
    clear = 1'b0;
    rate_ready = 1'b0;
    push(40);
    for (int i = 0; i < 256; i++) cyc(1'b1, i < 40);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clear_keeps_valid", int'(rate_valid), 1);
    chk("clear_keeps_count", int'(count_out), 40);
    rate_ready = 1'b1;
    idle(2);
    for (int i = 0; i < 255; i++) cyc(1'b1, 1'b1);
    clear = 1'b1;
    cyc(1'b1, 1'b1);
    clear = 1'b0;
    chk("clear_final_no_valid", int'(rate_valid), 0);
    idle(1);
    chk("clear_final_still_none", int'(rate_valid), 0);
    rate_ready = 1'b0;
    for (int i = 0; i < 306; i++) cyc(1'b1, 1'b1);
    chk("pre_rst_valid", int'(rate_valid), 1);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    chk("mid_rst_valid", int'(rate_valid), 0);
    chk("mid_rst_rate", int'(rate_out), 0);
    chk("mid_rst_count", int'(count_out), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    rate_ready = 1'b1;
    push(256);
    for (int i = 0; i < 256; i++) cyc(1'b1, 1'b1);
    idle(2);
    for (int w = 0; w < 16; w++) begin
      int c;
      c = 0;
      for (int i = 0; i < 256; i++) begin
        logic s;
        s = $urandom_range(255) < 128;
        c += int'(s);
        cyc(1'b1, s);
      end
      push(c);
      rate_sum += c > 255 ? 255 : c;
    end
    idle(3);
    chk("loop_mean_in_band", int'(rate_sum >= 112 * 16 && rate_sum <= 144 * 16), 1);
    chk("queue_drained", q.size(), 0);
    chk("overrun_pulses", ov_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Inverse of the Poisson spike encoder: recovers an 8-bit firing-rate estimate from a spike train.
- Counts spikes over a fixed window of 2^WIN_LOG2 enabled cycles.
- Scales the count to the encoder's rate domain (rate/2^RATE_WIDTH spike probability) and presents it on a valid/ready output.
- Sits at the output side of the crossbar/neuron array, or in encoder-loopback test harnesses.

Parameters:
- RATE_WIDTH, 8, width of rate_out; matches the encoder rate input.
- WIN_LOG2, 8, log2 of window length in enabled cycles (window = 256 by default); legal range 1..16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  sample enable; spike_in is sampled and the window advances only when en=1.
- clear  input  1  synchronous window restart; output register unaffected.
- spike_in  input  1  spike train, one spike per cycle max.
- rate_out  output  RATE_WIDTH  scaled rate of the last completed window.
- count_out  output  WIN_LOG2+1  raw spike count of the last completed window.
- rate_valid  output  1  result available.
- rate_ready  input  1  consumer accepts the result.
- overrun  output  1  one-cycle pulse: an unaccepted result was overwritten.

Behaviour:
- Reset (rst=1 at a clock edge): all registers cleared; rate_out=0, count_out=0, rate_valid=0, overrun=0, FSM=S_IDLE. Reset overrides clear and en, including mid-window.
- FSM states:
  - S_IDLE: counters at zero; first en=1 samples into the window and moves to S_ACCUM.
  - S_ACCUM: accumulating samples.
  - clear in any state returns to S_IDLE with counters zeroed.
- Sample counter (WIN_LOG2 bits) increments on each en=1 cycle. Spike counter (WIN_LOG2+1 bits) increments when en=1 and spike_in=1. Spikes with en=0 are ignored; counters hold.
- Window completes on the en=1 cycle where the sample counter equals 2^WIN_LOG2-1. That cycle's spike is included.
- Completion cycle:
  - Next window starts immediately with no gap.
  - Sample counter wraps to 0; spike counter restarts at 0.
- Result timing: count_out, rate_out and rate_valid update on the edge after the final sample (latency 1 cycle from the last sample).
- Scaling:
  - If WIN_LOG2 >= RATE_WIDTH: rate = count >> (WIN_LOG2-RATE_WIDTH).
  - Otherwise: rate = count << (RATE_WIDTH-WIN_LOG2).
  - Saturate at 2^RATE_WIDTH-1; a full window (count=2^WIN_LOG2) yields 255 by default.
- Handshake:
  - Transfer occurs on a cycle with rate_valid=1 and rate_ready=1.
  - After a transfer, rate_valid drops next cycle unless a new result loads in that same cycle.
  - rate_out and count_out are held stable while rate_valid=1 and no new result loads.
- New result while rate_valid=1 and rate_ready=0: data overwritten, rate_valid stays 1, overrun=1 for exactly that one cycle.
- New result in the same cycle as a transfer: no overrun; rate_valid stays 1 with the new data.
- clear and window completion in the same cycle: clear wins; no result is produced.
- clear has priority over en.
- clear with rate_valid=1: the pending result is retained.

Decomposition:
- Shared package (snn_pkg), holding:
  - RATE_WIDTH default (8), shared with the encoder.
  - FSM state encoding: S_IDLE, S_ACCUM.
  - A saturating-scale function (count, WIN_LOG2, RATE_WIDTH) -> rate.
- One natural sub-module: spike_window_counter.
  - Contains the sample and spike counters plus FSM.
  - Emits window_done and the final count.
  - The top level adds scaling and the valid/ready output register.

Test Plan:
- Defaults, en=1, spike_in=1 constant -> at clock 257 rate_valid=1, count_out=256, rate_out=255 (saturated), repeats every 256 cycles with rate_ready=1.
- Defaults, spike every 4th enabled cycle -> count_out=64, rate_out=64. Next window with no spikes -> count_out=0, rate_out=0.
- en toggling 1/0 each cycle, spike_in=1 always -> first result after 512 clocks, count_out=256; spikes on en=0 cycles uncounted.
- rate_ready=0 across two windows (spike rates 32 then 96) -> second result overwrites: rate_out=96, overrun high exactly one cycle, rate_valid stays 1. Then ready=1 for one cycle -> rate_valid=0 next cycle.
- clear after 100 samples with 30 spikes, then 256 samples with 40 spikes -> count_out=40. A clear coincident with the final sample produces no result and no rate_valid.
- rst asserted mid-window with rate_valid=1 -> next cycle all outputs 0. Loopback from spike_encoder rate=128 over 16 windows -> mean rate_out within 128±16.
